bp_mem_cmd_arbiter: RTL and testbench
=====================================

Name: bp_mem_cmd_arbiter

Overview:
- Shares one CCE-to-memory channel among num_req_p requesters (CCEs or I/O masters) with round-robin arbitration.
- Forwards the granted mem_cmd to memory and records the requester ID in an in-order routing FIFO.
- Steers each in-order mem_resp back to the requester that issued the command.
- Sits between the CCEs and the DRAM model/controller, upstream of the memory tracer taps.

Parameters:
- num_req_p, 2, number of requesters (>=2).
- msg_width_p, 512+64, width of a packed mem msg (header+data); passed through opaquely.
- max_outstanding_p, 4, routing FIFO depth (>=1): maximum commands in flight without a response.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_cmd_i  in  num_req_p*msg_width_p  per-requester commands; slice i belongs to requester i.
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  per-requester command consumed.
- mem_cmd_o  out  msg_width_p  command to memory.
- mem_cmd_v_o  out  1  command valid to memory.
- mem_cmd_yumi_i  in  1  memory consumes command this cycle.
- mem_resp_i  in  msg_width_p  response from memory.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  arbiter can accept response.
- req_resp_o  out  msg_width_p  response broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- outstanding_o  out  $clog2(max_outstanding_p+1)  commands in flight.
- error_o  out  1  sticky protocol error.

Behaviour:
- Async reset (reset_n_i low):
  - state=IDLE, grant=0, RR pointer=0, FIFO empty, outstanding_o=0, error_o=0.
  - All v/yumi/ready outputs 0.
- credit_ok = (outstanding count < max_outstanding_p). A same-cycle pop does NOT free a credit for a same-cycle push.
- State IDLE:
  - If credit_ok and any req_cmd_v_i, pick the first valid requester at or after the RR pointer (wrapping modulo num_req_p). This is purely combinational.
  - mem_cmd_v_o=1 and mem_cmd_o = that requester's slice, in the same cycle (zero-latency pass-through).
  - If mem_cmd_yumi_i: req_cmd_yumi_o[g]=1, push g into the FIFO, RR pointer <= g+1 (wrap), stay IDLE.
  - Else: register grant<=g and go to HOLD.
- State HOLD:
  - mem_cmd_v_o=1 with mem_cmd_o from req_cmd_i[grant]. No re-arbitration, so the offered command is stable until accepted.
  - On mem_cmd_yumi_i: yumi to grant, push grant, RR pointer <= grant+1, go to IDLE.
  - Requesters must hold valid until yumi. If req_cmd_v_i[grant] drops in HOLD: set error_o, go to IDLE with no push.
- The HOLD entry check already passed credit_ok, so HOLD never waits on credit.
- req_cmd_yumi_o is asserted only when mem_cmd_yumi_i is high, and at most one bit at a time.
- Response path (memory returns responses in command order):
  - head = FIFO head ID.
  - req_resp_v_o = onehot(head) & {num_req_p{mem_resp_v_i & ~empty}}.
  - mem_resp_ready_o = ~empty & req_resp_ready_i[head].
  - req_resp_o = mem_resp_i, combinational pass-through.
  - Pop on mem_resp_v_i & mem_resp_ready_o.
- mem_resp_v_i while FIFO empty: ready stays 0, no routing, error_o set (sticky until reset).
- Count: +1 on push, -1 on pop, unchanged on both or neither. It never exceeds max_outstanding_p.
- mem_cmd_yumi_i while mem_cmd_v_o=0 is ignored and sets error_o.
- Reset asserted mid-operation discards in-flight routing state immediately. No yumi or valid is produced in the reset cycle.

Test Plan:
- Single requester: req 0 valid, mem yumi same cycle -> req_cmd_yumi_o=01 in cycle 0, outstanding_o=1. Response with req_resp_ready_i=01 -> req_resp_v_o=01, mem_resp_ready_o=1, outstanding_o=0.
- Round-robin fairness: both valid continuously, memory yumi every cycle -> grant sequence 0,1,0,1. FIFO contents 0,1,0,1; four in-order responses go to 01,10,01,10.
- Backpressure/HOLD: req 1 only, mem_cmd_yumi_i low for 3 cycles -> mem_cmd_v_o=1 with req 1 data stable all 4 cycles. Req 0 raised in cycle 1 is not granted before req 1's yumi. Next grant is 0.
- Credit limit (max_outstanding_p=4): 4 accepted with no responses -> mem_cmd_v_o=0 despite valids. One response popped -> mem_cmd_v_o=1 the next cycle, not the same cycle.
- Response stall: head=1, req_resp_ready_i=01, mem_resp_v_i=1 -> mem_resp_ready_o=0, req_resp_v_o=10, no pop. Raising ready bit 1 -> pop that cycle.
- Errors/reset: mem_resp_v_i with empty FIFO -> error_o=1 next cycle, stays 1. Drop reset_n_i with 2 outstanding -> outstanding_o=0, error_o=0, all valids 0 asynchronously.

Source files
------------

// File: rtl/bp_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command channel among requesters,
// with an in-order routing FIFO that steers memory responses back to the issuer.
module bp_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 512+64,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_ready_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                             error_o
);

  localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w = $clog2(max_outstanding_p+1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_reg;
  logic [id_w-1:0]   grant_reg;
  logic [id_w-1:0]   rr_reg;
  logic [ptr_w-1:0]  wr_ptr_reg;
  logic [ptr_w-1:0]  rd_ptr_reg;
  logic [cnt_w-1:0]  count_reg;
  logic              error_reg;
  logic [id_w-1:0]   fifo_mem [max_outstanding_p];

  logic [msg_width_p-1:0] cmd_slice [num_req_p];
  logic [id_w-1:0]        pick;
  logic                   pick_found;
  int                     idx;
  logic [id_w-1:0]        sel;
  logic                   credit_ok;
  logic                   empty;
  logic                   cmd_v;
  logic                   push;
  logic                   pop;
  logic                   hold_drop;
  logic [id_w-1:0]        head;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_req
      assign cmd_slice[gi]      = req_cmd_i[gi*msg_width_p +: msg_width_p];
      assign req_cmd_yumi_o[gi] = push && (sel == id_w'(gi));
      assign req_resp_v_o[gi]   = mem_resp_v_i && !empty && (head == id_w'(gi));
    end
  endgenerate

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!pick_found && req_cmd_v_i[idx[id_w-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[id_w-1:0];
      end
    end
  end

  assign credit_ok = (count_reg < cnt_w'(max_outstanding_p));
  assign empty     = (count_reg == '0);
  assign sel       = (state_reg == HOLD) ? grant_reg : pick;
  assign hold_drop = (state_reg == HOLD) && !req_cmd_v_i[grant_reg];

  // Outputs are gated by the reset input so nothing is offered while reset is held.
  assign cmd_v = reset_n_i &&
                 ((state_reg == HOLD) ? req_cmd_v_i[grant_reg] : (credit_ok && pick_found));
  assign push  = cmd_v && mem_cmd_yumi_i;

  assign mem_cmd_v_o = cmd_v;
  assign mem_cmd_o   = cmd_slice[sel];

  assign head             = fifo_mem[rd_ptr_reg];
  assign mem_resp_ready_o = !empty && req_resp_ready_i[head];
  assign req_resp_o       = mem_resp_i;
  assign pop              = mem_resp_v_i && mem_resp_ready_o;

  assign outstanding_o = count_reg;
  assign error_o       = error_reg;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(max_outstanding_p-1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Routing storage needs no reset: the pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= sel;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_v && !mem_cmd_yumi_i) begin
            state_reg <= HOLD;
            grant_reg <= pick;
          end
        end
        HOLD: begin
          if (hold_drop || mem_cmd_yumi_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (push) begin
        rr_reg     <= (sel == id_w'(num_req_p-1)) ? '0 : sel + id_w'(1);
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);

      case ({push, pop})
        2'b10:   count_reg <= count_reg + cnt_w'(1);
        2'b01:   count_reg <= count_reg - cnt_w'(1);
        default: count_reg <= count_reg;
      endcase

      if ((mem_cmd_yumi_i && !cmd_v) || (mem_resp_v_i && empty) || hold_drop)
        error_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Self-checking bench for bp_mem_cmd_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_bp_mem_cmd_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int M  = 4;
  localparam int CW = $clog2(M+1);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*W-1:0]  req_cmd_i = '0;
  logic [N-1:0]    req_cmd_v_i = '0;
  logic [N-1:0]    req_cmd_yumi_o;
  logic [W-1:0]    mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_yumi_i = 1'b0;
  logic [W-1:0]    mem_resp_i = '0;
  logic            mem_resp_v_i = 1'b0;
  logic            mem_resp_ready_o;
  logic [W-1:0]    req_resp_o;
  logic [N-1:0]    req_resp_v_o;
  logic [N-1:0]    req_resp_ready_i = '0;
  logic [CW-1:0]   outstanding_o;
  logic            error_o;

  always #5 clk = ~clk;

  bp_mem_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: routing queue of requester IDs, RR pointer, held offer, sticky error.
  int mq[$];
  int m_rr   = 0;
  int m_hold = -1;
  bit m_err  = 1'b0;
  int m_push_id = -1;

  // Observed outputs of the last cycle, for scenario-specific checks.
  logic [N-1:0] obs_yumi, obs_resp_v;
  logic         obs_cmd_v, obs_rdy;
  logic [W-1:0] obs_cmd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void offer(input logic [N-1:0] v, output int id, output bit ev);
    id = -1;
    ev = 1'b0;
    if (m_hold >= 0) begin
      id = m_hold;
      ev = v[m_hold];
    end else if (mq.size() < M) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (v[j] && !ev) begin
          id = j;
          ev = 1'b1;
        end
      end
    end
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
  task automatic cycle(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic yumi, input logic rv, input logic [W-1:0] rd,
                       input logic [N-1:0] rrdy);
    int id;
    bit ev, push, pop, exp_rdy;
    logic [N-1:0] exp_yumi, exp_rv;
    req_cmd_v_i = v;
    req_cmd_i = {d1, d0};
    mem_cmd_yumi_i = yumi;
    mem_resp_v_i = rv;
    mem_resp_i = rd;
    req_resp_ready_i = rrdy;
    offer(v, id, ev);
    push     = ev && yumi;
    exp_yumi = push ? (N'(1) << id) : '0;
    exp_rv   = (rv && mq.size() > 0) ? (N'(1) << mq[0]) : '0;
    exp_rdy  = (mq.size() > 0) && rrdy[mq[0]];
    pop      = rv && exp_rdy;
    @(negedge clk);
    check("cmd_v", 64'(mem_cmd_v_o), 64'(ev));
    if (ev) check("cmd_data", 64'(mem_cmd_o), 64'((id == 0) ? d0 : d1));
    check("cmd_yumi", 64'(req_cmd_yumi_o), 64'(exp_yumi));
    check("resp_v", 64'(req_resp_v_o), 64'(exp_rv));
    check("resp_ready", 64'(mem_resp_ready_o), 64'(exp_rdy));
    if (rv) check("resp_data", 64'(req_resp_o), 64'(rd));
    check("outstanding", 64'(outstanding_o), 64'(mq.size()));
    check("error", 64'(error_o), 64'(m_err));
    $display("cycle t=%0t v=%b yumi=%b rv=%b rrdy=%b -> cmd_v=%b yumi_o=%b resp_v=%b rdy=%b out=%0d err=%b",
             $time, v, yumi, rv, rrdy, mem_cmd_v_o, req_cmd_yumi_o, req_resp_v_o,
             mem_resp_ready_o, outstanding_o, error_o);
    obs_yumi = req_cmd_yumi_o;
    obs_resp_v = req_resp_v_o;
    obs_cmd_v = mem_cmd_v_o;
    obs_rdy = mem_resp_ready_o;
    obs_cmd = mem_cmd_o;
    @(posedge clk);
    if ((yumi && !ev) || (rv && mq.size() == 0) || (m_hold >= 0 && !v[m_hold])) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    m_push_id = -1;
    if (push) begin
      mq.push_back(id);
      m_rr = (id + 1) % N;
      m_hold = -1;
      m_push_id = id;
    end else if (m_hold >= 0 && !v[m_hold]) begin
      m_hold = -1;
    end else if (m_hold < 0 && ev) begin
      m_hold = id;
    end
    #1;
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [W-1:0] pd [N];
    logic [N-1:0] seq [4];
    int id;
    bit ev;

    // Reset state, with valid inputs present while reset is held.
    req_cmd_v_i = 2'b11;
    mem_cmd_yumi_i = 1'b1;
    mem_resp_v_i = 1'b1;
    req_resp_ready_i = 2'b11;
    #12;
    check("rst_cmd_v", 64'(mem_cmd_v_o), 64'(0));
    check("rst_yumi", 64'(req_cmd_yumi_o), 64'(0));
    check("rst_resp_v", 64'(req_resp_v_o), 64'(0));
    check("rst_ready", 64'(mem_resp_ready_o), 64'(0));
    check("rst_out", 64'(outstanding_o), 64'(0));
    check("rst_err", 64'(error_o), 64'(0));
    req_cmd_v_i = '0;
    mem_cmd_yumi_i = 1'b0;
    mem_resp_v_i = 1'b0;
    req_resp_ready_i = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester: same-cycle yumi, then its response.
    cycle(2'b01, 32'hA0A0_0001, 32'h0, 1'b1, 1'b0, '0, 2'b00);
    check("single_yumi", 64'(obs_yumi), 64'(2'b01));
    check("single_out1", 64'(outstanding_o), 64'(1));
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hD00D_0001, 2'b01);
    check("single_resp_v", 64'(obs_resp_v), 64'(2'b01));
    check("single_rdy", 64'(obs_rdy), 64'(1));
    check("single_out0", 64'(outstanding_o), 64'(0));

    // Requester 1 once (pointer now 1), drain, so the fairness run starts at 0.
    cycle(2'b10, '0, 32'hB0B0_0001, 1'b1, 1'b0, '0, 2'b00);
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hD00D_0002, 2'b10);

    // Round-robin fairness.
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 32'hC000_0000 + i, 32'hC100_0000 + i, 1'b1, 1'b0, '0, 2'b00);
      seq[i] = obs_yumi;
    end
    check("rr_g0", 64'(seq[0]), 64'(2'b01));
    check("rr_g1", 64'(seq[1]), 64'(2'b10));
    check("rr_g2", 64'(seq[2]), 64'(2'b01));
    check("rr_g3", 64'(seq[3]), 64'(2'b10));
    check("credit_out", 64'(outstanding_o), 64'(4));

    // Credit limit: no offer while full; a pop does not free a credit the same cycle.
    cycle(2'b11, 32'h1, 32'h2, 1'b0, 1'b0, '0, 2'b00);
    check("credit_block", 64'(obs_cmd_v), 64'(0));
    cycle(2'b11, 32'h1, 32'h2, 1'b0, 1'b1, 32'hE1, 2'b11);
    check("credit_same", 64'(obs_cmd_v), 64'(0));
    check("resp_order0", 64'(obs_resp_v), 64'(2'b01));
    cycle(2'b11, 32'h1, 32'h2, 1'b0, 1'b1, 32'hE2, 2'b11);
    check("credit_next", 64'(obs_cmd_v), 64'(1));
    check("resp_order1", 64'(obs_resp_v), 64'(2'b10));
    cycle(2'b11, 32'h1, 32'h2, 1'b0, 1'b1, 32'hE3, 2'b11);
    check("resp_order2", 64'(obs_resp_v), 64'(2'b01));
    cycle(2'b11, 32'h1, 32'h2, 1'b1, 1'b1, 32'hE4, 2'b11);
    check("resp_order3", 64'(obs_resp_v), 64'(2'b10));
    check("hold0_yumi", 64'(obs_yumi), 64'(2'b01));

    // Response stall on head=1.
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hE5, 2'b01);
    cycle(2'b10, '0, 32'h0000_0B01, 1'b1, 1'b0, '0, 2'b00);
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hE6, 2'b01);
    check("stall_rdy", 64'(obs_rdy), 64'(0));
    check("stall_resp_v", 64'(obs_resp_v), 64'(2'b10));
    check("stall_out", 64'(outstanding_o), 64'(1));
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hE6, 2'b10);
    check("stall_pop", 64'(outstanding_o), 64'(0));

    // Backpressure: req 1 held for three cycles, req 0 arrives meanwhile.
    cycle(2'b10, 32'h5555_0000, 32'h1111_AAAA, 1'b0, 1'b0, '0, 2'b00);
    check("hold_d0", 64'(obs_cmd), 64'(32'h1111_AAAA));
    cycle(2'b11, 32'h5555_0000, 32'h1111_AAAA, 1'b0, 1'b0, '0, 2'b00);
    check("hold_d1", 64'(obs_cmd), 64'(32'h1111_AAAA));
    cycle(2'b11, 32'h5555_0000, 32'h1111_AAAA, 1'b0, 1'b0, '0, 2'b00);
    check("hold_d2", 64'(obs_cmd), 64'(32'h1111_AAAA));
    cycle(2'b11, 32'h5555_0000, 32'h1111_AAAA, 1'b1, 1'b0, '0, 2'b00);
    check("hold_yumi", 64'(obs_yumi), 64'(2'b10));
    cycle(2'b11, 32'h5555_0000, 32'h2222_BBBB, 1'b1, 1'b0, '0, 2'b00);
    check("hold_next", 64'(obs_yumi), 64'(2'b01));

    // Random traffic that obeys the protocol.
    pend = '0;
    for (int i = 0; i < N; i++) pd[i] = '0;
    for (int c = 0; c < 400; c++) begin
      logic y, rv;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          pd[i] = $urandom;
        end
      end
      offer(pend, id, ev);
      y  = ev && ($urandom_range(2, 0) != 0);
      rv = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
      cycle(pend, pd[0], pd[1], y, rv, $urandom, N'($urandom));
      if (m_push_id >= 0) pend[m_push_id] = 1'b0;
    end

    // Drain, then a response with an empty FIFO raises a sticky error.
    while (mq.size() > 0) cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hF0, 2'b11);
    if (m_hold >= 0) cycle(pend, pd[0], pd[1], 1'b1, 1'b0, '0, 2'b00);
    while (mq.size() > 0) cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hF0, 2'b11);
    cycle(2'b00, '0, '0, 1'b0, 1'b1, 32'hF1, 2'b11);
    check("err_set", 64'(error_o), 64'(1));
    cycle(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    check("err_sticky", 64'(error_o), 64'(1));

    // Two in flight, then an asynchronous reset in the middle of a cycle.
    cycle(2'b11, 32'h7, 32'h8, 1'b1, 1'b0, '0, 2'b00);
    cycle(2'b11, 32'h7, 32'h8, 1'b1, 1'b0, '0, 2'b00);
    check("pre_rst_out", 64'(outstanding_o), 64'(2));
    req_cmd_v_i = 2'b11;
    mem_cmd_yumi_i = 1'b1;
    mem_resp_v_i = 1'b1;
    req_resp_ready_i = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", 64'(outstanding_o), 64'(0));
    check("arst_err", 64'(error_o), 64'(0));
    check("arst_cmd_v", 64'(mem_cmd_v_o), 64'(0));
    check("arst_yumi", 64'(req_cmd_yumi_o), 64'(0));
    check("arst_resp_v", 64'(req_resp_v_o), 64'(0));
    check("arst_rdy", 64'(mem_resp_ready_o), 64'(0));
    mq.delete();
    m_rr = 0;
    m_hold = -1;
    m_err = 1'b0;
    req_cmd_v_i = '0;
    mem_cmd_yumi_i = 1'b0;
    mem_resp_v_i = 1'b0;
    req_resp_ready_i = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(2'b11, 32'h9, 32'hA, 1'b1, 1'b0, '0, 2'b00);
    check("post_rst_grant", 64'(obs_yumi), 64'(2'b01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
